// File: rtl/lsu_writeback_pkg.sv
// Shared definitions for the LSU/writeback stage: RV32I access-size codes,
// FSM state encoding and the store-lane helper functions.
package lsu_writeback_pkg;

    localparam int LSU_XLEN   = 32;
    localparam int LSU_ADDR_W = 32;

    // funct3 access codes (loads and stores share the size encoding)
    localparam logic [2:0] F3_B  = 3'b000;  // LB / SB
    localparam logic [2:0] F3_H  = 3'b001;  // LH / SH
    localparam logic [2:0] F3_W  = 3'b010;  // LW / SW
    localparam logic [2:0] F3_BU = 3'b100;  // LBU
    localparam logic [2:0] F3_HU = 3'b101;  // LHU

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_WB   = 3'd3,
        ST_ERR  = 3'd4
    } state_e;

    // An access traps on an unknown size code, an unsigned-store code, or a
    // half/word address that is not naturally aligned.
    function automatic logic access_traps(input logic       is_store,
                                          input logic [2:0] funct3,
                                          input logic [1:0] addr_lo);
        logic trap;
        case (funct3)
            F3_B:    trap = 1'b0;
            F3_BU:   trap = is_store;
            F3_H:    trap = addr_lo[0];
            F3_HU:   trap = is_store | addr_lo[0];
            F3_W:    trap = |addr_lo;
            default: trap = 1'b1;
        endcase
        return trap;
    endfunction

    // Byte strobes for a store; only legal (aligned) accesses reach here.
    function automatic logic [3:0] store_wmask(input logic [2:0] funct3,
                                               input logic [1:0] addr_lo);
        logic [3:0] mask;
        case (funct3)
            F3_B:    mask = 4'b0001 << addr_lo;
            F3_H:    mask = 4'b0011 << addr_lo;
            default: mask = 4'hF;
        endcase
        return mask;
    endfunction

    // Store data replicated across all lanes so the strobes pick the right one.
    function automatic logic [LSU_XLEN-1:0] store_wdata(input logic [2:0]          funct3,
                                                        input logic [LSU_XLEN-1:0] data);
        logic [LSU_XLEN-1:0] word;
        case (funct3)
            F3_B:    word = {4{data[7:0]}};
            F3_H:    word = {2{data[15:0]}};
            default: word = data;
        endcase
        return word;
    endfunction

endpackage

// File: rtl/lsu_writeback_load_extract.sv
// Combinational load formatter: selects the addressed byte/half from the
// returned word and sign- or zero-extends it according to funct3.
module load_extract
    import lsu_writeback_pkg::*;
#(
    parameter int XLEN = LSU_XLEN
) (
    input  logic [XLEN-1:0] rdata_i,
    input  logic [1:0]      addr_lo_i,
    input  logic [2:0]      funct3_i,
    output logic [XLEN-1:0] data_o
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Lane select followed by extension
    always_comb begin
        byte_lane = rdata_i[8*addr_lo_i +: 8];
        half_lane = rdata_i[16*addr_lo_i[1] +: 16];
        case (funct3_i)
            F3_B:    data_o = {{(XLEN-8){byte_lane[7]}}, byte_lane};
            F3_BU:   data_o = {{(XLEN-8){1'b0}}, byte_lane};
            F3_H:    data_o = {{(XLEN-16){half_lane[15]}}, half_lane};
            F3_HU:   data_o = {{(XLEN-16){1'b0}}, half_lane};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/lsu_writeback.sv
// Memory-access / writeback stage: takes one retiring instruction, performs
// at most one valid/ready memory access, and pulses the GPR write port.
module lsu_writeback
    import lsu_writeback_pkg::*;
#(
    parameter int XLEN   = LSU_XLEN,
    parameter int ADDR_W = LSU_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    // EXU side
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_is_load,
    input  logic              in_is_store,
    input  logic [2:0]        in_funct3,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [XLEN-1:0]   in_wdata,
    input  logic [4:0]        in_rd,
    input  logic [XLEN-1:0]   in_alu_result,
    // memory bus
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_wen,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [XLEN-1:0]   mem_req_wdata,
    output logic [3:0]        mem_req_wmask,
    input  logic              mem_resp_valid,
    input  logic [XLEN-1:0]   mem_resp_rdata,
    // GPR write port and status
    output logic              GPR_we,
    output logic [4:0]        GPR_writer,
    output logic [XLEN-1:0]   GPR_wd,
    output logic              done,
    output logic              misalign_err
);

    state_e              state_q,    state_d;
    logic                is_store_q, is_store_d;
    logic [2:0]          funct3_q,   funct3_d;
    logic [ADDR_W-1:0]   addr_q,     addr_d;
    logic [XLEN-1:0]     wdata_q,    wdata_d;
    logic [4:0]          rd_q,       rd_d;
    logic [XLEN-1:0]     wb_data_q,  wb_data_d;
    logic [XLEN-1:0]     load_data;

    load_extract #(.XLEN(XLEN)) u_load_extract (
        .rdata_i   (mem_resp_rdata),
        .addr_lo_i (addr_q[1:0]),
        .funct3_i  (funct3_q),
        .data_o    (load_data)
    );

    // State and latched instruction fields
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            is_store_q <= 1'b0;
            funct3_q   <= 3'b000;
            addr_q     <= '0;
            wdata_q    <= '0;
            rd_q       <= 5'd0;
            wb_data_q  <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state_q    <= state_d;
            is_store_q <= is_store_d;
            funct3_q   <= funct3_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rd_q       <= rd_d;
            wb_data_q  <= wb_data_d;
        end
    end

    // Next-state logic and field capture
    always_comb begin
        // NOTE: hold-current defaults first, so no path leaves a latch behind.
        state_d    = state_q;
        is_store_d = is_store_q;
        funct3_d   = funct3_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rd_d       = rd_q;
        wb_data_d  = wb_data_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    is_store_d = in_is_store;
                    funct3_d   = in_funct3;
                    addr_d     = in_addr;
                    wdata_d    = in_wdata;
                    rd_d       = in_rd;
                    wb_data_d  = in_alu_result;
                    if (!(in_is_load || in_is_store)) begin
                        state_d = ST_WB;
                    end else if (access_traps(in_is_store, in_funct3, in_addr[1:0])) begin
                        state_d = ST_ERR;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (mem_req_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_resp_valid) begin
                    if (is_store_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        wb_data_d = load_data;
                        state_d   = ST_WB;
                    end
                end
            end
            ST_WB:   state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from the current state; everything idles at zero
    always_comb begin
        in_ready      = 1'b0;
        mem_req_valid = 1'b0;
        mem_req_wen   = 1'b0;
        mem_req_addr  = '0;
        mem_req_wdata = '0;
        mem_req_wmask = 4'b0000;
        GPR_we        = 1'b0;
        GPR_writer    = 5'd0;
        GPR_wd        = '0;
        done          = 1'b0;
        misalign_err  = 1'b0;

        case (state_q)
            ST_IDLE: in_ready = 1'b1;
            ST_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_wen   = is_store_q;
                mem_req_addr  = {addr_q[ADDR_W-1:2], 2'b00};
                if (is_store_q) begin
                    mem_req_wdata = store_wdata(funct3_q, wdata_q);
                    mem_req_wmask = store_wmask(funct3_q, addr_q[1:0]);
                end
            end
            ST_WAIT: done = mem_resp_valid & is_store_q;
            ST_WB: begin
                GPR_we     = (rd_q != 5'd0);
                GPR_writer = rd_q;
                GPR_wd     = wb_data_q;
                done       = 1'b1;
            end
            ST_ERR: begin
                done         = 1'b1;
                misalign_err = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
